// File: rtl/opm_pkg.sv
// rtl/opm_pkg.sv - shared constants and state encoding for the OPM burst reader
//
// Purpose : default geometry of the OPM RAM, default burst length and the
//           reader state encoding, shared by the reader and its environment.
// Ports   : none (package).
package opm_pkg;

  localparam int OPM_DATA_SZ  = 16;
  localparam int OPM_ADDR_SZ  = 4;
  localparam int OPM_WORD_CNT = 11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_CAPT = 3'd2,
    ST_OUT  = 3'd3,
    ST_FIN  = 3'd4
  } opm_state_t;

endpackage

// File: rtl/opm_reader_if.sv
// rtl/opm_reader_if.sv - RAM read bus and captured-word handshake of the OPM reader
//
// Purpose : bundles the RAM-side bus (O_WE, O_ADDR_OPM, I_DATA_OPM) and the
//           consumer-side handshake (O_DATA, O_IDX, O_VALID, I_READY).
//           Signal names are as seen from the reader.
// Ports   : master - reader side (drives address, write enable and word)
//           slave  - environment side (returns RAM data and ready)
interface opm_reader_if #(
  parameter int DATA_OPM_SZ = 16,
  parameter int ADDR_OPM_SZ = 4
);

  logic                   O_WE;
  logic [ADDR_OPM_SZ-1:0] O_ADDR_OPM;
  logic [DATA_OPM_SZ-1:0] I_DATA_OPM;
  logic [DATA_OPM_SZ-1:0] O_DATA;
  logic [ADDR_OPM_SZ-1:0] O_IDX;
  logic                   O_VALID;
  logic                   I_READY;

  modport master (
    output O_WE, O_ADDR_OPM, O_DATA, O_IDX, O_VALID,
    input  I_DATA_OPM, I_READY
  );

  modport slave (
    input  O_WE, O_ADDR_OPM, O_DATA, O_IDX, O_VALID,
    output I_DATA_OPM, I_READY
  );

endinterface

// File: rtl/opm.sv
// rtl/opm.sv - OPM single-port RAM with registered read
//
// Purpose : 2**ADDR_OPM_SZ x DATA_OPM_SZ RAM; read data appears one cycle
//           after the address is presented.
// Ports   : CLK         clock
//           I_WE        write enable
//           I_ADDR_OPM  address (read and write)
//           I_DATA      write data
//           O_DATA      registered read data
module opm #(
  parameter int DATA_OPM_SZ = 16,
  parameter int ADDR_OPM_SZ = 4
) (
  input  logic                   CLK,
  input  logic                   I_WE,
  input  logic [ADDR_OPM_SZ-1:0] I_ADDR_OPM,
  input  logic [DATA_OPM_SZ-1:0] I_DATA,
  output logic [DATA_OPM_SZ-1:0] O_DATA
);

  logic [DATA_OPM_SZ-1:0] mem [2**ADDR_OPM_SZ];

  always_ff @(posedge CLK) begin
    if (I_WE) begin
      mem[I_ADDR_OPM] <= I_DATA;
    end
    O_DATA <= mem[I_ADDR_OPM];
  end

endmodule

// File: rtl/opm_reader.sv
// rtl/opm_reader.sv - burst reader: fetches WORD_CNT words from the OPM RAM
//
// Purpose : on I_START reads WORD_CNT consecutive RAM words from I_BASE_ADDR
//           (address wraps), presenting each word with its burst index
//           until the consumer accepts it.
// Ports   : CLK          clock, rising edge
//           RST_N        asynchronous active-low reset
//           I_START      burst request, sampled only in IDLE
//           I_ABORT      terminate burst at next edge
//           I_BASE_ADDR  first RAM address, captured with I_START
//           O_BUSY       high outside IDLE
//           O_DONE       one-cycle pulse after the last word is accepted
//           bus          RAM bus + word handshake (opm_reader_if.master)
module opm_reader
  import opm_pkg::*;
#(
  parameter int DATA_OPM_SZ = OPM_DATA_SZ,
  parameter int ADDR_OPM_SZ = OPM_ADDR_SZ,
  parameter int WORD_CNT    = OPM_WORD_CNT
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   I_START,
  input  logic                   I_ABORT,
  input  logic [ADDR_OPM_SZ-1:0] I_BASE_ADDR,
  output logic                   O_BUSY,
  output logic                   O_DONE,
  opm_reader_if.master           bus
);

  localparam logic [ADDR_OPM_SZ-1:0] LAST_IDX = ADDR_OPM_SZ'(WORD_CNT - 1);

  opm_state_t state, state_nx;

  logic [ADDR_OPM_SZ-1:0] addr_q;
  logic [ADDR_OPM_SZ-1:0] idx_q;
  logic [DATA_OPM_SZ-1:0] data_q;
  logic                   valid_q;

  logic load_base;
  logic advance;
  logic capture;
  logic clr_valid;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    load_base = 1'b0;
    advance   = 1'b0;
    capture   = 1'b0;
    clr_valid = 1'b0;
    // Abort wins over everything else, including an accept in OUT.
    if (state != ST_IDLE && I_ABORT) begin
      state_nx  = ST_IDLE;
      clr_valid = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (I_START && !I_ABORT) begin
            state_nx  = ST_REQ;
            load_base = 1'b1;
          end
        end
        ST_REQ: begin
          // Address is on the RAM for this cycle; data is valid in CAPT.
          state_nx = ST_CAPT;
        end
        ST_CAPT: begin
          capture  = 1'b1;
          state_nx = ST_OUT;
        end
        ST_OUT: begin
          if (bus.I_READY) begin
            clr_valid = 1'b1;
            if (idx_q == LAST_IDX) begin
              state_nx = ST_FIN;
            end else begin
              advance  = 1'b1;
              state_nx = ST_REQ;
            end
          end
        end
        ST_FIN: begin
          state_nx = ST_IDLE;
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (load_base) begin
        addr_q <= I_BASE_ADDR;
        idx_q  <= '0;
      end else if (advance) begin
        // Address wraps naturally at the RAM size; the index cannot wrap
        // because the last word leaves through FIN instead of advancing.
        addr_q <= addr_q + 1'b1;
        idx_q  <= idx_q + 1'b1;
      end
      if (capture) begin
        data_q  <= bus.I_DATA_OPM;
        valid_q <= 1'b1;
      end else if (clr_valid) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.O_WE       = 1'b0;
  assign bus.O_ADDR_OPM = addr_q;
  assign bus.O_DATA     = data_q;
  assign bus.O_IDX      = idx_q;
  assign bus.O_VALID    = valid_q;

  assign O_BUSY = (state != ST_IDLE);
  // An abort arriving in FIN still cancels the completion pulse.
  assign O_DONE = (state == ST_FIN) && !I_ABORT;

endmodule

// File: tb/tb_opm_reader.sv
// tb/tb_opm_reader.sv - directed self-checking bench for opm_reader with opm RAM
module tb_opm_reader;
  import opm_pkg::*;

  logic       CLK    = 1'b0;
  logic       RST_N  = 1'b1;
  logic       start  = 1'b0;
  logic       start3 = 1'b0;
  logic       abort  = 1'b0;
  logic       ready  = 1'b1;
  logic [3:0] base   = 4'h0;
  logic [3:0] base3  = 4'h0;
  logic       busy, done, busy3, done3;

  logic        ld      = 1'b1;
  logic        we      = 1'b0;
  logic [3:0]  ld_addr = 4'h0;
  logic [15:0] ld_data = 16'h0;
  logic [15:0] ram_q, ram3_q;

  int n_cmp = 0;
  int n_err = 0;

  always #10 CLK = ~CLK;

  opm_reader_if #(.DATA_OPM_SZ(16), .ADDR_OPM_SZ(4)) bus ();
  opm_reader_if #(.DATA_OPM_SZ(16), .ADDR_OPM_SZ(4)) bus3 ();

  opm_reader #(.DATA_OPM_SZ(16), .ADDR_OPM_SZ(4), .WORD_CNT(11)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .I_START(start), .I_ABORT(abort),
    .I_BASE_ADDR(base), .O_BUSY(busy), .O_DONE(done), .bus(bus)
  );

  opm_reader #(.DATA_OPM_SZ(16), .ADDR_OPM_SZ(4), .WORD_CNT(3)) u_dut3 (
    .CLK(CLK), .RST_N(RST_N), .I_START(start3), .I_ABORT(abort),
    .I_BASE_ADDR(base3), .O_BUSY(busy3), .O_DONE(done3), .bus(bus3)
  );

  opm #(.DATA_OPM_SZ(16), .ADDR_OPM_SZ(4)) u_ram (
    .CLK(CLK), .I_WE(we | bus.O_WE), .I_ADDR_OPM(ld ? ld_addr : bus.O_ADDR_OPM),
    .I_DATA(ld_data), .O_DATA(ram_q)
  );

  opm #(.DATA_OPM_SZ(16), .ADDR_OPM_SZ(4)) u_ram3 (
    .CLK(CLK), .I_WE(we | bus3.O_WE), .I_ADDR_OPM(ld ? ld_addr : bus3.O_ADDR_OPM),
    .I_DATA(ld_data), .O_DATA(ram3_q)
  );

  assign bus.I_DATA_OPM  = ram_q;
  assign bus.I_READY     = ready;
  assign bus3.I_DATA_OPM = ram3_q;
  assign bus3.I_READY    = ready;

  logic [15:0] g_data[$];
  logic [3:0]  g_idx[$];
  logic [3:0]  g_addr[$];
  int n_busy, n_done, first_valid, n_unstable, late_done, late_busy;
  logic aborted, post_valid, post_busy, post_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Runs one burst on the 11-word reader. hold_word stalls that word for
  // hold_cyc cycles, abort_word aborts while that word is presented,
  // start_word re-pulses I_START when that word appears (-1 disables each).
  task automatic run_burst(input logic [3:0] b, input int hold_word, input int hold_cyc,
                           input int abort_word, input int start_word);
    int held;
    int cyc;
    logic prev_v;
    logic [15:0] sd;
    logic [3:0] si, sa;
    held = 0; cyc = 0; prev_v = 1'b0; sd = '0; si = '0; sa = '0;
    g_data.delete(); g_idx.delete(); g_addr.delete();
    n_busy = 0; n_done = 0; first_valid = -1; n_unstable = 0; aborted = 1'b0;
    post_valid = 1'b0; post_busy = 1'b0; post_done = 1'b0;
    base = b; ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    while (busy && cyc < 300) begin
      start = 1'b0;
      cyc++;
      n_busy++;
      if (done) n_done++;
      if (bus.O_VALID) begin
        if (first_valid < 0) first_valid = n_busy;
        if (!prev_v) begin
          g_data.push_back(bus.O_DATA);
          g_idx.push_back(bus.O_IDX);
          g_addr.push_back(bus.O_ADDR_OPM);
          if (int'(bus.O_IDX) == start_word) start = 1'b1;
        end
        if (int'(bus.O_IDX) == hold_word) begin
          if (held == 0) begin
            sd = bus.O_DATA; si = bus.O_IDX; sa = bus.O_ADDR_OPM;
          end else if (bus.O_DATA !== sd || bus.O_IDX !== si || bus.O_ADDR_OPM !== sa) begin
            n_unstable++;
          end
          if (held < hold_cyc) begin
            ready = 1'b0;
            held++;
          end else begin
            ready = 1'b1;
          end
        end
        if (int'(bus.O_IDX) == abort_word) begin
          abort = 1'b1;
          tick();
          abort = 1'b0;
          aborted = 1'b1;
          post_valid = bus.O_VALID;
          post_busy = busy;
          post_done = done;
          break;
        end
      end
      prev_v = bus.O_VALID;
      tick();
    end
    start = 1'b0;
    if (!aborted) check_eq("burst_terminates", 32'(busy), 32'(0));
    late_done = 0;
    late_busy = 0;
    repeat (4) begin
      tick();
      if (done) late_done++;
      if (busy) late_busy++;
    end
    ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int n3_busy;
    int n3_done;
    logic [3:0] exp_addr3 [3];

    // Reset state
    #2 RST_N = 1'b0;
    #3;
    check_eq("rst_addr",  32'(bus.O_ADDR_OPM), 32'(0));
    check_eq("rst_data",  32'(bus.O_DATA), 32'(0));
    check_eq("rst_idx",   32'(bus.O_IDX), 32'(0));
    check_eq("rst_valid", 32'(bus.O_VALID), 32'(0));
    check_eq("rst_busy",  32'(busy), 32'(0));
    check_eq("rst_done",  32'(done), 32'(0));
    check_eq("rst_we",    32'(bus.O_WE), 32'(0));

    // Preload RAM[i] = 16'h1000 + i for the whole array
    ld = 1'b1;
    we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ld_addr = 4'(i);
      ld_data = 16'h1000 + 16'(i);
      tick();
    end
    we = 1'b0;
    ld = 1'b0;
    RST_N = 1'b1;
    tick();
    check_eq("idle_busy_after_release", 32'(busy), 32'(0));

    // Full burst, consumer always ready
    run_burst(4'h0, -1, 0, -1, -1);
    check_eq("b1_words", 32'(g_data.size()), 32'(11));
    for (int k = 0; k < 11 && k < g_data.size(); k++) begin
      check_eq($sformatf("b1_w%0d_data", k), 32'(g_data[k]), 32'(16'h1000 + 16'(k)));
      check_eq($sformatf("b1_w%0d_idx", k), 32'(g_idx[k]), 32'(k));
    end
    check_eq("b1_done_cnt", 32'(n_done), 32'(1));
    check_eq("b1_busy_cycles", 32'(n_busy), 32'(34));
    check_eq("b1_first_valid", 32'(first_valid), 32'(3));
    check_eq("b1_late_done", 32'(late_done), 32'(0));
    check_eq("b1_we", 32'(bus.O_WE), 32'(0));

    // Stall word 2 for five cycles
    run_burst(4'h0, 2, 5, -1, -1);
    check_eq("b2_words", 32'(g_data.size()), 32'(11));
    for (int k = 0; k < 11 && k < g_data.size(); k++) begin
      check_eq($sformatf("b2_w%0d_data", k), 32'(g_data[k]), 32'(16'h1000 + 16'(k)));
    end
    check_eq("b2_unstable", 32'(n_unstable), 32'(0));
    check_eq("b2_busy_cycles", 32'(n_busy), 32'(39));
    check_eq("b2_done_cnt", 32'(n_done), 32'(1));

    // Abort while word 4 is presented, then restart
    run_burst(4'h0, -1, 0, 4, -1);
    check_eq("b3_words", 32'(g_data.size()), 32'(5));
    check_eq("b3_post_valid", 32'(post_valid), 32'(0));
    check_eq("b3_post_busy", 32'(post_busy), 32'(0));
    check_eq("b3_post_done", 32'(post_done), 32'(0));
    check_eq("b3_done_cnt", 32'(n_done), 32'(0));
    check_eq("b3_late_done", 32'(late_done), 32'(0));
    run_burst(4'h0, -1, 0, -1, -1);
    check_eq("b4_words", 32'(g_data.size()), 32'(11));
    if (g_data.size() > 0) begin
      check_eq("b4_first_idx", 32'(g_idx[0]), 32'(0));
      check_eq("b4_first_data", 32'(g_data[0]), 32'(16'h1000));
    end
    check_eq("b4_done_cnt", 32'(n_done), 32'(1));

    // Start pulse during a burst is ignored and not queued
    run_burst(4'h0, -1, 0, -1, 3);
    check_eq("b5_words", 32'(g_data.size()), 32'(11));
    check_eq("b5_done_cnt", 32'(n_done), 32'(1));
    check_eq("b5_busy_cycles", 32'(n_busy), 32'(34));
    check_eq("b5_no_requeue", 32'(late_busy), 32'(0));

    // Asynchronous reset while in CAPT
    base = 4'h5;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("b6_busy_req", 32'(busy), 32'(1));
    check_eq("b6_addr_req", 32'(bus.O_ADDR_OPM), 32'(5));
    tick();
    RST_N = 1'b0;
    #1;
    check_eq("b6_rst_addr",  32'(bus.O_ADDR_OPM), 32'(0));
    check_eq("b6_rst_data",  32'(bus.O_DATA), 32'(0));
    check_eq("b6_rst_idx",   32'(bus.O_IDX), 32'(0));
    check_eq("b6_rst_valid", 32'(bus.O_VALID), 32'(0));
    check_eq("b6_rst_busy",  32'(busy), 32'(0));
    check_eq("b6_rst_done",  32'(done), 32'(0));
    #3 RST_N = 1'b1;
    repeat (3) tick();
    check_eq("b6_stays_idle", 32'(busy), 32'(0));
    check_eq("b6_no_valid", 32'(bus.O_VALID), 32'(0));

    // Three-word reader wrapping from address E
    exp_addr3[0] = 4'hE;
    exp_addr3[1] = 4'hF;
    exp_addr3[2] = 4'h0;
    g_data.delete(); g_idx.delete(); g_addr.delete();
    ready = 1'b1;
    base3 = 4'hE;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    cyc = 0; n3_busy = 0; n3_done = 0;
    while (busy3 && cyc < 100) begin
      cyc++;
      n3_busy++;
      if (done3) n3_done++;
      if (bus3.O_VALID) begin
        g_data.push_back(bus3.O_DATA);
        g_idx.push_back(bus3.O_IDX);
        g_addr.push_back(bus3.O_ADDR_OPM);
      end
      tick();
    end
    check_eq("w3_terminates", 32'(busy3), 32'(0));
    check_eq("w3_words", 32'(g_data.size()), 32'(3));
    for (int k = 0; k < 3 && k < g_data.size(); k++) begin
      check_eq($sformatf("w3_w%0d_addr", k), 32'(g_addr[k]), 32'(exp_addr3[k]));
      check_eq($sformatf("w3_w%0d_idx", k), 32'(g_idx[k]), 32'(k));
      check_eq($sformatf("w3_w%0d_data", k), 32'(g_data[k]), 32'(16'h1000 + 16'(exp_addr3[k])));
    end
    check_eq("w3_done_cnt", 32'(n3_done), 32'(1));
    check_eq("w3_busy_cycles", 32'(n3_busy), 32'(10));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/opm_reader.md
OPM_READER -- requirements
Module: opm_reader

Interface
REQ-001 SHALL have parameter DATA_OPM_SZ, default 16, RAM word width.
REQ-002 SHALL have parameter ADDR_OPM_SZ, default 4, RAM address width.
REQ-003 SHALL have parameter WORD_CNT, default 11, words per burst; legal range 1..2**ADDR_OPM_SZ.
REQ-004 SHALL have port CLK input 1: the one clock, 50 MHz; all logic on rising edge.
REQ-005 SHALL have port RST_N input 1: reset, asynchronous and active-low.
REQ-006 SHALL have port I_START input 1: burst request, sampled only in IDLE.
REQ-007 SHALL have port I_ABORT input 1: terminates the burst at the next edge.
REQ-008 SHALL have port I_BASE_ADDR input ADDR_OPM_SZ: first RAM address, captured with I_START.
REQ-009 SHALL have port I_DATA_OPM input DATA_OPM_SZ: RAM read data, valid one cycle after the address is presented.
REQ-010 SHALL have port I_READY input 1: consumer accepts O_DATA.
REQ-011 SHALL have port O_WE output 1: RAM write enable, tied 0.
REQ-012 SHALL have port O_ADDR_OPM output ADDR_OPM_SZ: RAM address, registered.
REQ-013 SHALL have port O_DATA output DATA_OPM_SZ: captured word.
REQ-014 SHALL have port O_IDX output ADDR_OPM_SZ: burst index (0..WORD_CNT-1) of O_DATA.
REQ-015 SHALL have port O_VALID output 1: O_DATA/O_IDX valid.
REQ-016 SHALL have port O_BUSY output 1: high in every state except IDLE.
REQ-017 SHALL have port O_DONE output 1: one-cycle pulse after the last word is accepted.

Function
REQ-018 SHALL implement states IDLE, REQ, CAPT, OUT, FIN.
REQ-019 IDLE with I_START=1 SHALL load O_ADDR_OPM<=I_BASE_ADDR, O_IDX<=0, and go to REQ.
REQ-020 REQ SHALL hold O_ADDR_OPM for one cycle, then go to CAPT.
REQ-021 CAPT SHALL register O_DATA<=I_DATA_OPM, set O_VALID, and go to OUT.
REQ-022 OUT SHALL hold O_DATA, O_IDX and O_VALID stable until I_READY=1; I_READY outside OUT is ignored.
REQ-023 On OUT with I_READY=1 and O_IDX<WORD_CNT-1, the block SHALL clear O_VALID, increment O_ADDR_OPM and O_IDX, and go to REQ.
REQ-024 On OUT with I_READY=1 and O_IDX=WORD_CNT-1, the block SHALL clear O_VALID and go to FIN.
REQ-025 FIN SHALL assert O_DONE for exactly one cycle, then go to IDLE.
REQ-026 Latency SHALL be: I_START edge to first O_VALID = 3 cycles; accept to next O_VALID = 3 cycles; burst minimum = 3*WORD_CNT+1 cycles.
REQ-027 O_ADDR_OPM SHALL wrap modulo 2**ADDR_OPM_SZ (e.g. 4'hF+1=4'h0); O_IDX SHALL never wrap.
REQ-028 I_START while O_BUSY=1 SHALL be ignored, with no queueing.
REQ-029 I_ABORT=1 in any non-IDLE state SHALL go to IDLE, clear O_VALID, and suppress O_DONE; abort has priority over I_READY.
REQ-030 I_START and I_ABORT together in IDLE SHALL leave the block in IDLE.
REQ-031 O_WE SHALL be 0 at all times.

Reset
REQ-032 RST_N=0 SHALL asynchronously force IDLE and set O_ADDR_OPM=0, O_DATA=0, O_IDX=0, O_VALID=0, O_BUSY=0, O_DONE=0.
REQ-033 Reset assertion mid-burst SHALL discard the burst; after release, only a new I_START starts a burst.

Structure
REQ-034 The state encoding and the default WORD_CNT constant SHALL live in a shared package, opm_pkg.
REQ-035 The block SHALL have no sub-module; the bench SHALL instantiate it with opm (DATA_OPM_SZ=16, ADDR_OPM_SZ=4) as the RAM, with O_ADDR_OPM to I_ADDR_OPM and O_DATA to I_DATA_OPM.

Verification
REQ-036 Preload RAM[0..10]=16'h1000+i, base=0, I_READY=1 -> 11 words 16'h1000..16'h100A, O_IDX 0..10, one O_DONE, 34 cycles.
REQ-037 Base=4'hE, WORD_CNT=3 -> addresses E, F, 0 read in order; O_IDX 0, 1, 2.
REQ-038 Hold I_READY=0 for 5 cycles during word 2 -> O_DATA and O_IDX stable throughout, no address change, then continue.
REQ-039 Pulse I_ABORT during OUT of word 4 -> IDLE next cycle, O_VALID=0, no O_DONE; a new I_START restarts at O_IDX=0.
REQ-040 Assert RST_N=0 mid-CAPT -> all outputs 0 immediately, without waiting for CLK.
REQ-041 Pulse I_START during a burst -> ignored; exactly one O_DONE.
